// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port index, default watchdog limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } arb_state_e;

    typedef logic port_idx_t;

    localparam int unsigned DefaultTimeoutCycles = 255;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the port not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_idx_t  last_grant_i,
    output logic       gnt_valid_o,
    output port_idx_t  gnt_idx_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        if (&req_i) begin
            gnt_idx_o = ~last_grant_i;
        end else begin
            gnt_idx_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (IDLE accept -> ACCESS handshake -> DONE response).
// Define MEM_ARB_TIMEOUT_EN to enable the ACCESS-state watchdog.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W         = `DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_m0_valid,
    input  logic              i_m0_we,
    input  logic [31:0]       i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ready,
    output logic              o_m0_done,
    output logic [DATA_W-1:0] o_m0_rdata,
    output logic              o_m0_err,
    input  logic              i_m1_valid,
    input  logic              i_m1_we,
    input  logic [31:0]       i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ready,
    output logic              o_m1_done,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_m1_err,
    output logic [31:0]       o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_wr_valid,
    input  logic              i_mem_wr_ready,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_mem_rd_valid,
    output logic              o_mem_rd_ready,
    input  logic              i_mem_invalid_addr
);

    arb_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    port_idx_t         idx_q, idx_d;
    port_idx_t         last_grant_q, last_grant_d;

    logic      gnt_valid;
    port_idx_t gnt_idx;
    logic      accept;
    logic      complete;
    logic      rsp_err;
    logic      tmo_hit;

    rr_arb2 u_rr_arb2 (
        .req_i       ({i_m1_valid, i_m0_valid}),
        .last_grant_i(last_grant_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Reset gates the combinational ready so no output leaks while held in reset.
    assign accept = i_rst_n && (state_q == StIdle) && gnt_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TmoW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (accept) begin
            tmo_cnt_d = '0;
        end else if (state_q == StAccess) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Count holds N-1 in the Nth ACCESS cycle, so that cycle is the last one.
    assign tmo_hit = (state_q == StAccess) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    p_tmo_nonzero : assert property (@(posedge i_clk) TIMEOUT_CYCLES > 0);

    always_comb begin
        complete = 1'b0;
        rsp_err  = 1'b0;
        if (state_q == StAccess) begin
            if (i_mem_invalid_addr || tmo_hit) begin
                complete = 1'b1;
                rsp_err  = 1'b1;
            end else if (we_q) begin
                complete = i_mem_wr_ready;
            end else begin
                complete = i_mem_rd_valid;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: if (complete) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        if (accept) begin
            idx_d        = gnt_idx;
            last_grant_d = gnt_idx;
            we_d         = gnt_idx ? i_m1_we    : i_m0_we;
            addr_d       = gnt_idx ? i_m1_addr  : i_m0_addr;
            wdata_d      = gnt_idx ? i_m1_wdata : i_m0_wdata;
        end
        if (complete) begin
            err_d   = rsp_err;
            rdata_d = (rsp_err || we_q) ? '0 : i_mem_data;
        end
        // Done is registered from DONE, so the pulse lands in the cycle after it.
        done_d = (state_q == StDone);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            idx_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        o_mem_addr     = '0;
        o_mem_data     = '0;
        o_mem_wr_valid = 1'b0;
        o_mem_rd_ready = 1'b0;
        if (state_q == StAccess) begin
            o_mem_addr     = addr_q;
            o_mem_data     = wdata_q;
            o_mem_wr_valid = we_q;
            o_mem_rd_ready = !we_q;
        end
        o_m0_ready = accept && (gnt_idx == 1'b0);
        o_m1_ready = accept && (gnt_idx == 1'b1);
        o_m0_done  = done_q && (idx_q == 1'b0);
        o_m1_done  = done_q && (idx_q == 1'b1);
        o_m0_err   = o_m0_done && err_q;
        o_m1_err   = o_m1_done && err_q;
        o_m0_rdata = o_m0_done ? rdata_q : '0;
        o_m1_rdata = o_m1_done ? rdata_q : '0;
    end

endmodule
